fpalu_multiplier_pipelined: RTL and testbench

FPALU_MULTIPLIER_PIPELINED -- requirements
Module: fpalu_multiplier_pipelined

---
 rtl/fpalu_multiplier_pipelined.sv | 190 +++++++++++++++++++
 tb/tb_fpalu_multiplier_pipelined.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpalu_multiplier_pipelined.sv
// Purpose : 3-stage pipelined floating-point multiplier (flush-to-zero, canonical qNaN).
// Latency : result appears at out_valid 3 cycles after an in_valid && in_ready transfer.
// Backpress: whole pipe advances only when the output slot is empty or drained (in_ready = advance).
//
// Ports   : clk, rst_n (sync, active-low); in_valid/in_ready/a/b operand side;
//           out_valid/out_ready/product/flags result side, flags = {invalid, overflow, underflow}.
// Config  : define FPALU_MUL_ROUND_NEAREST_EN for round-to-nearest-even; default truncates toward zero.
module fpalu_multiplier_pipelined #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   product,
   output logic [2:0]             flags
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int MW = MAN_W + 1;          // significand including hidden one
   localparam int PW = 2 * MW;             // full significand product
   localparam int EW = EXP_W + 2;          // signed exponent with headroom for sum and carries

   localparam logic signed [EW-1:0] BIAS   = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] E_ONE  = EW'(1);
   localparam logic signed [EW-1:0] E_ZERO = EW'(0);

`ifdef FPALU_MUL_ROUND_NEAREST_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif

   typedef enum logic [1:0] {K_NUM, K_ZERO, K_INF, K_NAN} kind_t;

   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // ---------------- S1: unpack, sign, exponent sum, classify ----------------
   logic               sa, sb;
   logic [EXP_W-1:0]   ea, eb;
   logic [MAN_W-1:0]   fa, fb;
   assign {sa, ea, fa} = a;
   assign {sb, eb, fb} = b;

   logic a_max, b_max, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
   assign a_max  = &ea;
   assign b_max  = &eb;
   assign a_zero = ~|ea;                   // subnormals flush to zero
   assign b_zero = ~|eb;
   assign a_nan  = a_max && (|fa);
   assign b_nan  = b_max && (|fb);
   assign a_inf  = a_max && !(|fa);
   assign b_inf  = b_max && !(|fb);

   kind_t                 k1;
   logic                  inv1;
   logic signed [EW-1:0]  esum1;

   always_comb begin
      k1   = K_NUM;
      inv1 = 1'b0;
      if (a_nan || b_nan) begin
         k1 = K_NAN;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         k1   = K_NAN;
         inv1 = 1'b1;
      end else if (a_inf || b_inf) begin
         k1 = K_INF;
      end else if (a_zero || b_zero) begin
         k1 = K_ZERO;
      end
   end

   assign esum1 = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

   logic                 s1_vld, s1_sign, s1_inv;
   logic signed [EW-1:0] s1_exp;
   logic [MW-1:0]        s1_ma, s1_mb;
   kind_t                s1_kind;

   // ---------------- S2: significand multiply ----------------
   logic                 s2_vld, s2_sign, s2_inv;
   logic signed [EW-1:0] s2_exp;
   logic [PW-1:0]        s2_prod;
   kind_t                s2_kind;

   // ---------------- S3: normalise, round, pack, flags ----------------
   logic [PW-1:0]        p_al;
   logic [MW-1:0]        m_norm;
   logic                 g, r, st, up;
   logic [MW:0]          m_rnd;
   logic [MAN_W-1:0]     frac;
   logic signed [EW-1:0] e_n, e_r;
   logic [W-1:0]         prod_d;
   logic [2:0]           flg_d;

   always_comb begin
      // Product of two [1,2) significands lies in [1,4): at most one bit of normalisation.
      p_al   = s2_prod[PW-1] ? s2_prod : (s2_prod << 1);
      e_n    = s2_prod[PW-1] ? (s2_exp + E_ONE) : s2_exp;
      m_norm = p_al[PW-1 -: MW];
      g      = p_al[PW-MW-1];
      r      = p_al[PW-MW-2];
      st     = |p_al[PW-MW-3:0];
      up     = RNE && g && (r || st || m_norm[0]);
      m_rnd  = {1'b0, m_norm} + {{MW{1'b0}}, up};
      // Rounding carry (1.11..1 + ulp) lands exactly on a power of two.
      if (m_rnd[MW]) begin
         frac = m_rnd[MAN_W:1];
         e_r  = e_n + E_ONE;
      end else begin
         frac = m_rnd[MAN_W-1:0];
         e_r  = e_n;
      end

      prod_d = '0;
      flg_d  = 3'b000;
      case (s2_kind)
         K_NAN: begin
            prod_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flg_d  = {s2_inv, 2'b00};
         end
         K_INF:  prod_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         K_ZERO: prod_d = {s2_sign, {(W-1){1'b0}}};
         default: begin
            if (e_r >= EMAX) begin
               prod_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               flg_d  = 3'b010;
            end else if (e_r <= E_ZERO) begin
               prod_d = {s2_sign, {(W-1){1'b0}}};
               flg_d  = 3'b001;
            end else begin
               prod_d = {s2_sign, e_r[EXP_W-1:0], frac};
            end
         end
      endcase
   end

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld    <= 1'b0;
         s1_sign   <= 1'b0;
         s1_inv    <= 1'b0;
         s1_exp    <= '0;
         s1_ma     <= '0;
         s1_mb     <= '0;
         s1_kind   <= K_NUM;
         s2_vld    <= 1'b0;
         s2_sign   <= 1'b0;
         s2_inv    <= 1'b0;
         s2_exp    <= '0;
         s2_prod   <= '0;
         s2_kind   <= K_NUM;
         out_valid <= 1'b0;
         product   <= '0;
         flags     <= '0;
      end else if (advance) begin
         s1_vld    <= in_valid;
         s1_sign   <= sa ^ sb;
         s1_inv    <= inv1;
         s1_exp    <= esum1;
         s1_ma     <= {1'b1, fa};
         s1_mb     <= {1'b1, fb};
         s1_kind   <= k1;

         s2_vld    <= s1_vld;
         s2_sign   <= s1_sign;
         s2_inv    <= s1_inv;
         s2_exp    <= s1_exp;
         s2_prod   <= PW'(s1_ma) * PW'(s1_mb);
         s2_kind   <= s1_kind;

         out_valid <= s2_vld;
         if (s2_vld) begin
            product <= prod_d;
            flags   <= flg_d;
         end
      end
   end

endmodule

// File: tb/tb_fpalu_multiplier_pipelined.sv
// Purpose : self-checking bench for fpalu_multiplier_pipelined (binary32 defaults).
// Latency : expects results 3 cycles after acceptance when the output is not stalled.
// Backpress: exercises out_ready stalls, mid-flight reset and back-to-back issue.
module tb_fpalu_multiplier_pipelined;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] product;
   logic [2:0]  flags;

   fpalu_multiplier_pipelined #(.EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] prod;
      logic [2:0]  flg;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t sbq[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Independent binary32 reference: flush-to-zero, canonical qNaN.
   function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
      logic        s;
      int          ex, ey, e;
      logic [22:0] fx, fy;
      logic [47:0] p;
      logic [24:0] m;
      logic [23:0] low;
      bit          rne, up;
`ifdef FPALU_MUL_ROUND_NEAREST_EN
      rne = 1'b1;
`else
      rne = 1'b0;
`endif
      s  = x[31] ^ y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      fx = x[22:0];
      fy = y[22:0];
      if ((ex == 255 && fx != 0) || (ey == 255 && fy != 0)) return {3'b000, 32'h7fc00000};
      if ((ex == 255 && ey == 0) || (ey == 255 && ex == 0)) return {3'b100, 32'h7fc00000};
      if (ex == 255 || ey == 255) return {3'b000, s, 8'hff, 23'h0};
      if (ex == 0 || ey == 0) return {3'b000, s, 31'h0};
      p = 48'({1'b1, fx}) * 48'({1'b1, fy});
      e = ex + ey - 127;
      if (p[47]) begin
         m   = {1'b0, p[47:24]};
         low = p[23:0];
         e   = e + 1;
      end else begin
         m   = {1'b0, p[46:23]};
         low = {p[22:0], 1'b0};
      end
      up = rne && low[23] && ((low[22:0] != 0) || m[0]);
      m  = m + 25'(up);
      if (m[24]) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e >= 255) return {3'b010, s, 8'hff, 23'h0};
      if (e <= 0)   return {3'b001, s, 31'h0};
      return {3'b000, s, e[7:0], m[22:0]};
   endfunction

   // Issue one operand pair; the expected result is queued on the cycle it is accepted.
   task automatic op(input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] ep, input logic [2:0] ef, input bit lat);
      bit got;
      got      = 1'b0;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sbq.push_back('{prod: ep, flg: ef, acc: cyc, lat: lat});
            got = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!got) chk("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sbq.size() != 0; i++) @(posedge clk);
      if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
      #1;
   endtask

   // Output monitor: compares every valid output cycle against the queue head,
   // which also proves the output holds steady while stalled.
   bit fresh = 1'b1;
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("spurious_out", out_valid, 0);
         end else begin
            chk("product", product, sbq[0].prod);
            chk("flags", flags, sbq[0].flg);
            if (fresh && sbq[0].lat) chk("latency", cyc - sbq[0].acc, 3);
            if (out_ready) void'(sbq.pop_front());
         end
         fresh = out_ready;
      end else begin
         fresh = 1'b1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_product", product, 0);
      chk("rst_flags", flags, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single operation and back-to-back pair
      op(32'h40d00000, 32'h41400000, 32'h429c0000, 3'b000, 1'b1);
      drain();
      op(32'h40d00000, 32'h41400000, 32'h429c0000, 3'b000, 1'b1);
      op(32'hc0c00000, 32'h41400000, 32'hc2900000, 3'b000, 1'b1);
      drain();

      // special cases and boundaries
      op(32'h7f800000, 32'h00000000, 32'h7fc00000, 3'b100, 1'b1);
      op(32'h7f000000, 32'h7f000000, 32'h7f800000, 3'b010, 1'b1);
      op(32'h00800000, 32'h00800000, 32'h00000000, 3'b001, 1'b1);
      op(32'h7fc00001, 32'h3f800000, 32'h7fc00000, 3'b000, 1'b1);
      op(32'hff800000, 32'h40000000, 32'hff800000, 3'b000, 1'b1);
      op(32'h7f800000, 32'hff800000, 32'hff800000, 3'b000, 1'b1);
      op(32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 1'b1);
      op(32'h00000001, 32'h40000000, 32'h00000000, 3'b000, 1'b1);
`ifdef FPALU_MUL_ROUND_NEAREST_EN
      op(32'h3f800001, 32'h3fc00000, 32'h3fc00002, 3'b000, 1'b1);
`else
      op(32'h3f800001, 32'h3fc00000, 32'h3fc00001, 3'b000, 1'b1);
`endif
      drain();

      // reference-model driven vectors, half restricted to mid-range exponents
      for (int i = 0; i < 24; i++) begin
         logic [31:0] x, y;
         logic [34:0] rm;
         x = $urandom;
         y = $urandom;
         if (i % 2 == 0) begin
            x[30:23] = 8'($urandom_range(100, 150));
            y[30:23] = 8'($urandom_range(100, 150));
         end
         rm = model(x, y);
         op(x, y, rm[31:0], rm[34:32], 1'b1);
      end
      drain();

      // output stalled for 5 cycles while four operations are offered
      out_ready = 1'b0;
      fork
         begin
            op(32'h3f800000, 32'h40000000, 32'h40000000, 3'b000, 1'b0);
            op(32'h40400000, 32'h40400000, 32'h41100000, 3'b000, 1'b0);
            op(32'hbf800000, 32'h40800000, 32'hc0800000, 3'b000, 1'b0);
            op(32'h3f000000, 32'h3f000000, 32'h3e800000, 3'b000, 1'b0);
         end
         begin
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // reset with two operations in flight
      op(32'h40d00000, 32'h41400000, 32'h429c0000, 3'b000, 1'b0);
      op(32'hc0c00000, 32'h41400000, 32'hc2900000, 3'b000, 1'b0);
      rst_n = 1'b0;
      sbq.delete();
      @(posedge clk);
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      op(32'h40d00000, 32'h41400000, 32'h429c0000, 3'b000, 1'b1);
      drain();
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
